// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the address error check.
package apb_pkg;

  localparam int APB_ADDR_W = 33;
  localparam int APB_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Misaligned or beyond the last word; bit 32 of the bus address is never passed in.
  function automatic logic apb_addr_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32 word store: single-cycle write, combinational read, cleared by preset.
// No backpressure; the write strobe is honoured on every edge it is high.
module apb_slave_regfile #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [31:0]       wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer over a word register file; pready rises WAIT_STATES+1 cycles after setup.
// Stalls the initiator with pready=0 while counting; a psel drop before completion aborts.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  apb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic [31:0]      addr_cur;
  logic             err_cur;
  logic             raise;
  logic             we;
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [31:0]      rdata;
  logic             unused_paddr_msb;

  assign unused_paddr_msb = paddr[32];

  // With zero wait states pready rises on the setup edge, before the latch holds the address.
  assign addr_cur = (state_q == IDLE) ? paddr[31:0] : addr_q;
  assign err_cur  = apb_addr_err(addr_cur, 32'(DEPTH));
  assign ridx     = addr_cur[IDX_W+1:2];
  assign widx     = addr_q[IDX_W+1:2];
  assign we       = (state_q == ACCESS) && pready_q && write_q && !pslverr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    raise     = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          addr_d  = paddr[31:0];
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = WS;
          raise   = (WS == 4'd0);
        end
      end
      ACCESS: begin
        if (pready_q || !psel) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d = 4'd0;
          raise = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (raise) begin
      pready_d  = 1'b1;
      pslverr_d = err_cur;
      if (!write_d) begin
        prdata_d = err_cur ? 32'h0 : rdata;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (we),
    .waddr (widx),
    .wdata (wdata_q),
    .raddr (ridx),
    .rdata (rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: three completers (0, 1 and 3 wait states) on one bus, selected by psel.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [32:0] paddr;
  logic [31:0] pwdata;
  int          which;

  logic        psel0, psel1, psel3;
  logic [31:0] prdata0, prdata1, prdata3;
  logic        pready0, pready1, pready3;
  logic        pslverr0, pslverr1, pslverr3;
  logic [31:0] cur_prdata;
  logic        cur_pready, cur_pslverr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  assign psel0 = psel && (which == 0);
  assign psel1 = psel && (which == 1);
  assign psel3 = psel && (which == 3);

  always_comb begin
    cur_prdata  = prdata1;
    cur_pready  = pready1;
    cur_pslverr = pslverr1;
    if (which == 0) begin
      cur_prdata  = prdata0;
      cur_pready  = pready0;
      cur_pslverr = pslverr0;
    end else if (which == 3) begin
      cur_prdata  = prdata3;
      cur_pready  = pready3;
      cur_pslverr = pslverr3;
    end
  end

  apb_slave_mem #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_slave_mem #(.DEPTH(16), .WAIT_STATES(1)) dut1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  apb_slave_mem #(.DEPTH(16), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transfer; the bus address/data are scrambled during ACCESS so only latched values may matter.
  task automatic xfer(input logic wr, input logic [32:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = a ^ 33'h4; pwdata = ~d;
    lat = 1;
    while (!cur_pready && lat < 20) begin
      @(posedge pclk); #1;
      lat++;
    end
    rd = cur_prdata;
    er = cur_pslverr;
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    which = 1; preset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(posedge pclk); #1;
    chk("reset_pready", {31'b0, pready1}, 32'h0);
    chk("reset_pslverr", {31'b0, pslverr1}, 32'h0);
    chk("reset_prdata", prdata1, 32'h0);

    xfer(1'b0, 33'h0, 32'h0, rd, er, lat);
    chk("rd0_data", rd, 32'h0);
    chk("rd0_err", {31'b0, er}, 32'h0);
    chk("rd0_lat", 32'(lat), 32'd2);

    // Write then back-to-back read, no idle cycle in between.
    xfer(1'b1, 33'h04, 32'hDEADBEEF, rd, er, lat);
    chk("wr4_err", {31'b0, er}, 32'h0);
    chk("wr4_lat", 32'(lat), 32'd2);
    xfer(1'b0, 33'h04, 32'h0, rd, er, lat);
    chk("b2b_rd4_data", rd, 32'hDEADBEEF);
    chk("b2b_rd4_lat", 32'(lat), 32'd2);
    go_idle();
    chk("pready_one_cycle", {31'b0, pready1}, 32'h0);
    chk("prdata_holds", prdata1, 32'hDEADBEEF);

    xfer(1'b1, 33'h40, 32'h12345678, rd, er, lat);
    chk("wr40_err", {31'b0, er}, 32'h1);
    chk("wr40_prdata_kept", rd, 32'hDEADBEEF);
    xfer(1'b0, 33'h00, 32'h0, rd, er, lat);
    chk("rd0_after_oor", rd, 32'h0);
    chk("rd0_after_oor_err", {31'b0, er}, 32'h0);
    xfer(1'b0, 33'h40, 32'h0, rd, er, lat);
    chk("rd40_data", rd, 32'h0);
    chk("rd40_err", {31'b0, er}, 32'h1);

    xfer(1'b1, 33'h06, 32'hCAFEF00D, rd, er, lat);
    chk("wr6_err", {31'b0, er}, 32'h1);
    xfer(1'b0, 33'h04, 32'h0, rd, er, lat);
    chk("rd4_after_misalign", rd, 32'hDEADBEEF);

    // Bit 32 is decoded by the initiator, not here.
    xfer(1'b1, 33'h1_0000_0010, 32'h00000055, rd, er, lat);
    chk("wr_bit32_err", {31'b0, er}, 32'h0);
    xfer(1'b0, 33'h10, 32'h0, rd, er, lat);
    chk("rd_bit32_alias", rd, 32'h00000055);

    xfer(1'b1, 33'h08, 32'h22222222, rd, er, lat);
    go_idle();
    // Abort: setup, then psel dropped in the first access cycle.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'h08; pwdata = 32'h11111111;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("abort_no_pready", {31'b0, pready1}, 32'h0);
    end
    xfer(1'b0, 33'h08, 32'h0, rd, er, lat);
    chk("rd8_after_abort", rd, 32'h22222222);
    go_idle();

    // Reset lands while a write to 0x0C is in its wait state.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'h0C; pwdata = 32'h33333333;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    chk("midrst_pready", {31'b0, pready1}, 32'h0);
    chk("midrst_pslverr", {31'b0, pslverr1}, 32'h0);
    chk("midrst_prdata", prdata1, 32'h0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 33'h04, 32'h0, rd, er, lat);
    chk("rd4_zeroed", rd, 32'h0);
    xfer(1'b0, 33'h08, 32'h0, rd, er, lat);
    chk("rd8_zeroed", rd, 32'h0);
    xfer(1'b0, 33'h0C, 32'h0, rd, er, lat);
    chk("rdC_write_dropped", rd, 32'h0);
    go_idle();

    // psel with penable and no setup phase must be ignored.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 33'h00; pwdata = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("nosetup_no_pready", {31'b0, pready1}, 32'h0);
    end
    go_idle();
    xfer(1'b0, 33'h00, 32'h0, rd, er, lat);
    chk("rd0_after_nosetup", rd, 32'h0);
    go_idle();

    which = 0;
    xfer(1'b1, 33'h0C, 32'hA5A5A5A5, rd, er, lat);
    chk("ws0_wr_lat", 32'(lat), 32'd1);
    xfer(1'b0, 33'h0C, 32'h0, rd, er, lat);
    chk("ws0_rd_lat", 32'(lat), 32'd1);
    chk("ws0_rd_data", rd, 32'hA5A5A5A5);
    xfer(1'b0, 33'h41, 32'h0, rd, er, lat);
    chk("ws0_err", {31'b0, er}, 32'h1);
    go_idle();
    chk("ws0_pslverr_clears", {31'b0, pslverr0}, 32'h0);

    which = 3;
    xfer(1'b1, 33'h3C, 32'h5A5A0001, rd, er, lat);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    xfer(1'b0, 33'h3C, 32'h0, rd, er, lat);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_rd_data", rd, 32'h5A5A0001);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
